// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end: synchronises the raw line, deframes characters
// and hands bytes to the core over a valid/ready handshake with error flags.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       out_d;
    logic             valid_d;
    logic             ovr_d;
    logic             fe_d;
    logic             busy_d;
    logic             byte_done;
    logic             stop_fail;

    // Line idles high, so the synchroniser resets to ones to avoid a false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_out   <= out_d;
            data_valid <= valid_d;
            frame_err  <= fe_d;
            overrun    <= ovr_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_fail = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Mid-start-bit check rejects short low glitches.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        stop_fail = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        if (!ena) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            idx_d     = '0;
            byte_done = 1'b0;
            stop_fail = 1'b0;
        end
    end

    // A completed byte replaces the held one only if the slot is free or being
    // consumed this edge; otherwise it is dropped and flagged.
    always_comb begin
        out_d   = data_out;
        valid_d = data_valid;
        ovr_d   = overrun;
        fe_d    = stop_fail;
        busy_d  = (state_d != S_IDLE);

        if (data_valid && data_ready) begin
            valid_d = 1'b0;
        end
        if (clr_err) begin
            ovr_d = 1'b0;
        end
        if (byte_done) begin
            if (!data_valid || data_ready) begin
                out_d   = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: bytes expected are queued as frames
// are driven and compared when the DUT hands them over.
module tb_uart_rx_frontend;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;
    logic       busy;

    int         tests = 0;
    int         fails = 0;
    int         fe_count = 0;
    int         deliveries = 0;
    logic [7:0] sb_q[$];

    uart_rx_frontend #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendBit(input logic b);
        rx_in = b;
        tick(CPB);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic expect_byte);
        if (expect_byte) sb_q.push_back(b);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(stop_bit);
    endtask

    // Consumption happens on the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_count++;
            if (data_valid && data_ready) begin
                deliveries++;
                if (sb_q.size() == 0) begin
                    checkOutput("sb_underflow", sb_q.size(), 1);
                end else begin
                    checkOutput("data_out", data_out, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] partial;
        int         d0;

        rst        = 1'b1;
        ena        = 1'b1;
        rx_in      = 1'b1;
        data_ready = 1'b1;
        clr_err    = 1'b0;
        tick(3);
        checkOutput("rst_valid", data_valid, 0);
        checkOutput("rst_data", data_out, 0);
        checkOutput("rst_fe", frame_err, 0);
        checkOutput("rst_ovr", overrun, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        tick(5);

        // 1: single byte, consumer ready
        applyStimulus(8'hA5, 1'b1, 1'b1);
        checkOutput("t1_valid_pulse", data_valid, 0);
        tick(5);
        checkOutput("t1_deliv", deliveries, 1);
        checkOutput("t1_fe", fe_count, 0);
        checkOutput("t1_ovr", overrun, 0);

        // 2: short low glitch while idle
        rx_in = 1'b0;
        tick(3);
        rx_in = 1'b1;
        checkOutput("t2_busy_hi", busy, 1);
        tick(10);
        checkOutput("t2_busy_lo", busy, 0);
        checkOutput("t2_deliv", deliveries, 1);
        checkOutput("t2_fe", fe_count, 0);

        // 3: bad stop bit, then a good frame
        applyStimulus(8'h3C, 1'b0, 1'b0);
        rx_in = 1'b1;
        tick(20);
        checkOutput("t3_fe_once", fe_count, 1);
        checkOutput("t3_valid", data_valid, 0);
        checkOutput("t3_busy", busy, 0);
        applyStimulus(8'h81, 1'b1, 1'b1);
        tick(5);
        checkOutput("t3_deliv", deliveries, 3 - 1);

        // 4: overrun with consumer stalled
        data_ready = 1'b0;
        applyStimulus(8'h11, 1'b1, 1'b1);
        tick(5);
        checkOutput("t4_ovr_pre", overrun, 0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        tick(5);
        checkOutput("t4_ovr", overrun, 1);
        checkOutput("t4_hold_data", data_out, 8'h11);
        checkOutput("t4_hold_valid", data_valid, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checkOutput("t4_clr", overrun, 0);
        d0 = deliveries;
        data_ready = 1'b1;
        tick(2);
        checkOutput("t4_deliv", deliveries, d0 + 1);
        checkOutput("t4_valid_drop", data_valid, 0);

        // 5: back-to-back frames
        d0 = deliveries;
        applyStimulus(8'h55, 1'b1, 1'b1);
        applyStimulus(8'hAA, 1'b1, 1'b1);
        tick(5);
        checkOutput("t5_deliv", deliveries, d0 + 2);
        checkOutput("t5_ovr", overrun, 0);

        // 6: reset during data bit 4
        partial = 8'hF0;
        d0 = deliveries;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(partial[i]);
        rx_in = partial[4];
        tick(3);
        checkOutput("t6_busy_mid", busy, 1);
        rst = 1'b1;
        tick(1);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_valid", data_valid, 0);
        checkOutput("t6_data", data_out, 0);
        checkOutput("t6_fe", frame_err, 0);
        checkOutput("t6_ovr", overrun, 0);
        rst = 1'b0;
        for (int i = 5; i < 8; i++) sendBit(partial[i]);
        sendBit(1'b1);
        tick(20);
        checkOutput("t6_no_byte", deliveries, d0);
        checkOutput("t6_valid_after", data_valid, 0);
        checkOutput("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
